writeback_stage: RTL

Parametrised successor to the single-cycle writeback mux: the MEM/WB pipeline register, load-data formatting, result selection, and link-register steering in one block. It also adds a small in-order queue that accepts results from long-latency units (multiply/divide) through a valid/ready handshake. Queued results are written into free register-file write slots, meaning cycles in which the pipeline instruction in W does not write. It sits between the memory stage and the register-file write port.

---
 rtl/writeback_stage_if.sv | 51 +++++
 rtl/writeback_stage.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage_if.sv
// Bus bundle for writeback_stage.
// Carries the M-stage inputs, the late-result handshake and the register-file write port.
// The master modport is the upstream/driver side; the slave modport is the writeback stage.
interface writeback_stage_if #(
    parameter int WIDTH    = 32,
    parameter int REGW     = 5,
    parameter int LQ_DEPTH = 2
);
    localparam int CNTW = $clog2(LQ_DEPTH + 1);

    // Pipeline control and data from the memory stage
    logic             StallW;
    logic             FlushW;
    logic             RegWriteM;
    logic             JumpM;
    logic             MemToRegM;
    logic [1:0]       LoadSizeM;
    logic             LoadUnsignedM;
    logic [1:0]       ByteOffM;
    logic [REGW-1:0]  WriteRegM;
    logic [WIDTH-1:0] ReadDataM;
    logic [WIDTH-1:0] ALUOutM;
    logic [WIDTH-1:0] PCPlus8M;

    // Late-result handshake (multiply/divide units)
    logic             LateValid;
    logic             LateReady;
    logic [REGW-1:0]  LateReg;
    logic [WIDTH-1:0] LateData;

    // Register-file write port and status
    logic             RegWriteW;
    logic [REGW-1:0]  WriteRegW;
    logic [WIDTH-1:0] ResultW;
    logic             LateWriteW;
    logic [CNTW-1:0]  LQCount;

    modport master (
        output StallW, FlushW, RegWriteM, JumpM, MemToRegM, LoadSizeM,
               LoadUnsignedM, ByteOffM, WriteRegM, ReadDataM, ALUOutM, PCPlus8M,
               LateValid, LateReg, LateData,
        input  LateReady, RegWriteW, WriteRegW, ResultW, LateWriteW, LQCount
    );

    modport slave (
        input  StallW, FlushW, RegWriteM, JumpM, MemToRegM, LoadSizeM,
               LoadUnsignedM, ByteOffM, WriteRegM, ReadDataM, ALUOutM, PCPlus8M,
               LateValid, LateReg, LateData,
        output LateReady, RegWriteW, WriteRegW, ResultW, LateWriteW, LQCount
    );
endinterface

// File: rtl/writeback_stage.sv
// Writeback stage: MEM/WB register, load formatting, result selection, link-register
// steering, and an in-order late-result queue that fills idle register-file write slots.
// WIDTH must be a multiple of 16 and at least 32; LQ_DEPTH is 1..8.
module writeback_stage #(
    parameter int WIDTH    = 32,
    parameter int REGW     = 5,
    parameter int LINK_REG = 31,
    parameter int LQ_DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    writeback_stage_if.slave bus
);
    localparam int CNTW = $clog2(LQ_DEPTH + 1);
    localparam int PTRW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam logic [REGW-1:0] LINK_ADDR = REGW'(LINK_REG);

    typedef struct packed {
        logic             reg_write;
        logic             jump;
        logic             mem_to_reg;
        logic [1:0]       load_size;
        logic             load_unsigned;
        logic [1:0]       byte_off;
        logic [REGW-1:0]  write_reg;
        logic [WIDTH-1:0] read_data;
        logic [WIDTH-1:0] alu_out;
        logic [WIDTH-1:0] pc_plus8;
    } mw_t;

    mw_t mw_d, mw_q;

    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] pipe_result;
    logic [REGW-1:0]  dest;
    logic             pwe;

    logic [REGW-1:0]     lq_reg_d  [LQ_DEPTH];
    logic [REGW-1:0]     lq_reg_q  [LQ_DEPTH];
    logic [WIDTH-1:0]    lq_data_d [LQ_DEPTH];
    logic [WIDTH-1:0]    lq_data_q [LQ_DEPTH];
    logic [LQ_DEPTH-1:0] lq_live_d, lq_live_q;
    logic [PTRW-1:0]     rd_ptr_d, rd_ptr_q;
    logic [PTRW-1:0]     wr_ptr_d, wr_ptr_q;
    logic [CNTW-1:0]     count_d, count_q;
    logic                lq_empty;
    logic                push;
    logic                pop;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(LQ_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // MEM/WB register next state: flush beats stall beats capture
    always_comb begin
        mw_d = mw_q;
        if (bus.FlushW) begin
            mw_d = '0;
        end else if (!bus.StallW) begin
            mw_d.reg_write     = bus.RegWriteM;
            mw_d.jump          = bus.JumpM;
            mw_d.mem_to_reg    = bus.MemToRegM;
            mw_d.load_size     = bus.LoadSizeM;
            mw_d.load_unsigned = bus.LoadUnsignedM;
            mw_d.byte_off      = bus.ByteOffM;
            mw_d.write_reg     = bus.WriteRegM;
            mw_d.read_data     = bus.ReadDataM;
            mw_d.alu_out       = bus.ALUOutM;
            mw_d.pc_plus8      = bus.PCPlus8M;
        end
    end

    // MEM/WB register; reset loads a bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            mw_q <= '0;
        end else begin
            mw_q <= mw_d;
        end
    end

    // Little-endian load formatting; half-word lane uses only byte_off[1]
    always_comb begin
        ld_byte = mw_q.read_data[7:0];
        case (mw_q.byte_off)
            2'd1:    ld_byte = mw_q.read_data[15:8];
            2'd2:    ld_byte = mw_q.read_data[23:16];
            2'd3:    ld_byte = mw_q.read_data[31:24];
            default: ld_byte = mw_q.read_data[7:0];
        endcase
        ld_half  = mw_q.byte_off[1] ? mw_q.read_data[31:16] : mw_q.read_data[15:0];
        load_val = mw_q.read_data;
        case (mw_q.load_size)
            2'b01:   load_val = {{(WIDTH-16){~mw_q.load_unsigned & ld_half[15]}}, ld_half};
            2'b10:   load_val = {{(WIDTH-8){~mw_q.load_unsigned & ld_byte[7]}}, ld_byte};
            default: load_val = mw_q.read_data;
        endcase
    end

    // Pipeline result, effective destination and write enable (r0 never written)
    always_comb begin
        dest = mw_q.jump ? LINK_ADDR : mw_q.write_reg;
        pwe  = (mw_q.reg_write | mw_q.jump) & (dest != '0);
        if (mw_q.jump) begin
            pipe_result = mw_q.pc_plus8;
        end else if (mw_q.mem_to_reg) begin
            pipe_result = load_val;
        end else begin
            pipe_result = mw_q.alu_out;
        end
    end

    // Queue handshake: ready ignores a same-cycle pop, drain only in idle write slots
    always_comb begin
        lq_empty      = (count_q == '0);
        bus.LateReady = (count_q < CNTW'(LQ_DEPTH));
        push          = bus.LateValid & bus.LateReady;
        pop           = ~pwe & ~lq_empty;
        bus.LQCount   = count_q;
    end

    // Queue next state; a W write to R kills every queued R, including one arriving now
    always_comb begin
        lq_reg_d  = lq_reg_q;
        lq_data_d = lq_data_q;
        lq_live_d = lq_live_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        if (push) begin
            lq_reg_d[wr_ptr_q]  = bus.LateReg;
            lq_data_d[wr_ptr_q] = bus.LateData;
            lq_live_d[wr_ptr_q] = (bus.LateReg != '0);
            wr_ptr_d            = ptr_inc(wr_ptr_q);
        end
        for (int i = 0; i < LQ_DEPTH; i++) begin
            if (pwe && (lq_reg_d[i] == dest)) begin
                lq_live_d[i] = 1'b0;
            end
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Queue control state; reset empties the queue
    always_ff @(posedge clk) begin
        if (reset) begin
            lq_live_q <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            lq_live_q <= lq_live_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
        end
    end

    // Queue payload; entries are only observed while counted and live
    always_ff @(posedge clk) begin
        lq_reg_q  <= lq_reg_d;
        lq_data_q <= lq_data_d;
    end

    // Write port: pipeline owns the slot when it writes, otherwise the queue head
    always_comb begin
        bus.RegWriteW  = 1'b0;
        bus.WriteRegW  = dest;
        bus.ResultW    = pipe_result;
        bus.LateWriteW = 1'b0;
        if (pwe) begin
            bus.RegWriteW = 1'b1;
        end else if (!lq_empty) begin
            bus.WriteRegW  = lq_reg_q[rd_ptr_q];
            bus.ResultW    = lq_data_q[rd_ptr_q];
            bus.RegWriteW  = lq_live_q[rd_ptr_q];
            bus.LateWriteW = lq_live_q[rd_ptr_q];
        end
    end
endmodule
